// File: rtl/sram_arb_pkg.sv
// Shared constants and the arbiter state encoding for the SRAM arbiter slice.
// Requester indices fix the priority order: VGA first, then the round-robin group.
package sram_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int READ_LATENCY = 3;

    localparam int REQ_VGA  = 0;
    localparam int REQ_UART = 1;
    localparam int REQ_M1   = 2;
    localparam int REQ_M2   = 3;

    typedef enum logic [1:0] {
        S_ARB_IDLE   = 2'd0,
        S_ARB_BUSY   = 2'd1,
        S_ARB_LOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: scans the request vector starting at ptr, wrapping once,
// and returns a one-hot winner (all zeros when nothing is requested).
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!found && req[(int'(ptr) + off) % N]) begin
                gnt[(int'(ptr) + off) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: VGA has absolute priority, the other requesters share
// the bus round-robin, with optional burst locking and a fixed-latency read return.
module sram_arbiter #(
    parameter int NUM_REQ      = sram_arb_pkg::NUM_REQ,
    parameter int READ_LATENCY = sram_arb_pkg::READ_LATENCY
) (
    input  logic                     Clock_50,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       Req_i,
    input  logic [NUM_REQ-1:0]       Req_we_i,
    input  logic [NUM_REQ-1:0][17:0] Req_addr_i,
    input  logic [NUM_REQ-1:0][15:0] Req_wdata_i,
    input  logic [NUM_REQ-1:0]       Lock_i,
    output logic [NUM_REQ-1:0]       Gnt_o,
    output logic [NUM_REQ-1:0]       Rvalid_o,
    output logic [15:0]              Rdata_o,
    output logic [17:0]              SRAM_address_o,
    output logic [15:0]              SRAM_write_data_o,
    output logic                     SRAM_we_n_o,
    input  logic [15:0]              SRAM_read_data_i,
    output logic [1:0]               Dbg_state_o
);
    import sram_arb_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);

    // Handshake: an access is accepted on any rising edge where Req_i[i] and Gnt_o[i]
    // are both high; the requester holds we/addr/wdata stable until that edge.

    arb_state_e state, state_nx;
    logic [IDW-1:0] owner, owner_nx;
    logic [IDW-1:0] rr_ptr, rr_ptr_nx;
    logic [IDW-1:0] win_idx;
    logic [NUM_REQ-1:0] rr_req, rr_gnt, gnt;
    logic accept;

    logic           pipe_v  [READ_LATENCY];
    logic [IDW-1:0] pipe_id [READ_LATENCY];

    always_comb begin
        rr_req          = Req_i;
        rr_req[REQ_VGA] = 1'b0;
    end

    rr_priority_picker #(.N(NUM_REQ)) u_rr_picker (
        .req (rr_req),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    // Locked bus is shared only with VGA; the owner keeps it even between accepts.
    always_comb begin
        gnt = '0;
        if (!Reset) begin
            if (Req_i[REQ_VGA])
                gnt[REQ_VGA] = 1'b1;
            else if (state == S_ARB_LOCKED)
                gnt[owner] = Req_i[owner];
            else
                gnt = rr_gnt;
        end
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) win_idx = IDW'(i);
    end

    assign accept = |gnt;
    assign Gnt_o  = gnt;

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        case (state)
            S_ARB_LOCKED: begin
                if (!Lock_i[owner]) state_nx = S_ARB_IDLE;
            end
            default: begin
                state_nx = accept ? S_ARB_BUSY : S_ARB_IDLE;
                if (accept && win_idx != IDW'(REQ_VGA)) begin
                    rr_ptr_nx = (win_idx == IDW'(NUM_REQ - 1)) ? IDW'(REQ_UART) : win_idx + 1'b1;
                    if (Lock_i[win_idx]) begin
                        state_nx = S_ARB_LOCKED;
                        owner_nx = win_idx;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state             <= S_ARB_IDLE;
            owner             <= '0;
            rr_ptr            <= IDW'(REQ_UART);
            SRAM_address_o    <= '0;
            SRAM_write_data_o <= '0;
            SRAM_we_n_o       <= 1'b1;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_v[i]  <= 1'b0;
                pipe_id[i] <= '0;
            end
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            rr_ptr <= rr_ptr_nx;
            if (accept) begin
                SRAM_address_o    <= Req_addr_i[win_idx];
                SRAM_write_data_o <= Req_wdata_i[win_idx];
                SRAM_we_n_o       <= ~Req_we_i[win_idx];
            end else begin
                SRAM_we_n_o <= 1'b1;
            end
            pipe_v[0]  <= accept && !Req_we_i[win_idx];
            pipe_id[0] <= win_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    always_comb begin
        Rvalid_o = '0;
        if (!Reset && pipe_v[READ_LATENCY-1])
            Rvalid_o[pipe_id[READ_LATENCY-1]] = 1'b1;
    end

    assign Rdata_o     = (Rvalid_o != '0) ? SRAM_read_data_i : '0;
    assign Dbg_state_o = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: hand-computed grant sequences drive expectation
// queues; a negedge monitor pops them against grants, SRAM writes and read returns.
module tb_sram_arbiter;

    logic             Clock_50 = 1'b0;
    logic             Reset;
    logic [3:0]       Req_i, Req_we_i, Lock_i;
    logic [3:0][17:0] Req_addr_i;
    logic [3:0][15:0] Req_wdata_i;
    logic [3:0]       Gnt_o, Rvalid_o;
    logic [15:0]      Rdata_o, SRAM_write_data_o, SRAM_read_data_i;
    logic [17:0]      SRAM_address_o;
    logic             SRAM_we_n_o;
    logic [1:0]       Dbg_state_o;

    sram_arbiter dut (
        .Clock_50          (Clock_50),
        .Reset             (Reset),
        .Req_i             (Req_i),
        .Req_we_i          (Req_we_i),
        .Req_addr_i        (Req_addr_i),
        .Req_wdata_i       (Req_wdata_i),
        .Lock_i            (Lock_i),
        .Gnt_o             (Gnt_o),
        .Rvalid_o          (Rvalid_o),
        .Rdata_o           (Rdata_o),
        .SRAM_address_o    (SRAM_address_o),
        .SRAM_write_data_o (SRAM_write_data_o),
        .SRAM_we_n_o       (SRAM_we_n_o),
        .SRAM_read_data_i  (SRAM_read_data_i),
        .Dbg_state_o       (Dbg_state_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #10 Clock_50 = ~Clock_50;

    int cyc = 0;
    always @(posedge Clock_50) cyc <= cyc + 1;

    // ---------------- SRAM model (two-stage read pipeline) ----------------
    logic [15:0] sram_mem [int];
    logic [15:0] rd_q1, rd_q2;

    function automatic logic [15:0] fill(input logic [17:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    always @(posedge Clock_50) begin
        rd_q1 <= sram_mem.exists(int'(SRAM_address_o)) ? sram_mem[int'(SRAM_address_o)]
                                                         : fill(SRAM_address_o);
        rd_q2 <= rd_q1;
        if (SRAM_we_n_o === 1'b0) sram_mem[int'(SRAM_address_o)] = SRAM_write_data_o;
    end
    assign SRAM_read_data_i = rd_q2;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [3:0]  gnt_exp_q [$];
    logic [49:0] rd_exp_q  [$];   // {accept_cyc[31:0], id[1:0], data[15:0]}
    logic [65:0] wr_exp_q  [$];   // {accept_cyc[31:0], addr[17:0], data[15:0]}
    logic [15:0] exp_mem   [int];
    logic [17:0] addr_r [4];
    logic [15:0] wdata_r [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [17:0] a);
        return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : fill(a);
    endfunction

    logic [3:0]  mon_g;
    logic [49:0] mon_r;
    logic [65:0] mon_w;

    always @(negedge Clock_50) begin
        if (gnt_exp_q.size() > 0) begin
            mon_g = gnt_exp_q.pop_front();
            chk("gnt", Gnt_o, mon_g);
        end
        if (Rvalid_o !== 4'b0000) begin
            if (rd_exp_q.size() == 0) chk("unexpected_rvalid", Rvalid_o, 0);
            else begin
                mon_r = rd_exp_q.pop_front();
                chk("rvalid_id", Rvalid_o, 4'b0001 << mon_r[17:16]);
                chk("rdata", Rdata_o, mon_r[15:0]);
                chk("rvalid_cycle", cyc, mon_r[49:18] + 2);
            end
        end
        if (SRAM_we_n_o === 1'b0) begin
            if (wr_exp_q.size() == 0) chk("unexpected_write", SRAM_we_n_o, 1);
            else begin
                mon_w = wr_exp_q.pop_front();
                chk("sram_addr", SRAM_address_o, mon_w[33:16]);
                chk("sram_wdata", SRAM_write_data_o, mon_w[15:0]);
                chk("write_cycle", cyc, mon_w[65:34]);
            end
        end
    end

    // ---------------- driver ----------------
    // One cycle of stimulus plus the hand-computed grant; track=0 drops read returns.
    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] we,
                         input logic [3:0] lock, input logic [3:0] exp_gnt, input bit track);
        Reset    = rst;
        Req_i    = req;
        Req_we_i = we;
        Lock_i   = lock;
        for (int k = 0; k < 4; k++) begin
            Req_addr_i[k]  = addr_r[k];
            Req_wdata_i[k] = wdata_r[k];
        end
        gnt_exp_q.push_back(exp_gnt);
        for (int k = 0; k < 4; k++) begin
            if (exp_gnt[k]) begin
                if (we[k]) begin
                    wr_exp_q.push_back({32'(cyc + 1), addr_r[k], wdata_r[k]});
                    exp_mem[int'(addr_r[k])] = wdata_r[k];
                end else if (track) begin
                    rd_exp_q.push_back({32'(cyc + 1), 2'(k), exp_rd(addr_r[k])});
                end
                addr_r[k]  += 18'd1;
                wdata_r[k] += 16'h0101;
            end
        end
        @(posedge Clock_50);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we_n"}, SRAM_we_n_o, 1);
        chk({tag, "_addr"}, SRAM_address_o, 0);
        chk({tag, "_wdata"}, SRAM_write_data_o, 0);
        chk({tag, "_rvalid"}, Rvalid_o, 0);
        chk({tag, "_rdata"}, Rdata_o, 0);
        chk({tag, "_state"}, Dbg_state_o, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        Reset       = 1'b1;
        Req_i       = '0;
        Req_we_i    = '0;
        Lock_i      = '0;
        Req_addr_i  = '0;
        Req_wdata_i = '0;
        for (int k = 0; k < 4; k++) begin
            addr_r[k]  = 18'(k * 4096 + 16);
            wdata_r[k] = 16'(k * 16'h1000 + 1);
        end
        @(posedge Clock_50);
        #1;

        // Reset: grants held low even with every requester asking.
        drive(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk_reset_outputs("reset");

        // Round-robin over 1..3, all reads.
        for (int i = 0; i < 6; i++)
            drive(1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0010 << (i % 3), 1'b1);
        idle(4);

        // VGA wins every cycle, then rotation resumes from requester 1.
        for (int i = 0; i < 4; i++)
            drive(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0010 << i, 1'b1);
        idle(4);

        // Write BEEF by requester 2, read it back through requester 3.
        addr_r[2]  = 18'd27648;
        wdata_r[2] = 16'hBEEF;
        addr_r[3]  = 18'd27648;
        drive(1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1);
        idle(1);
        drive(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b1);
        idle(4);

        // Burst lock by requester 1 with a VGA pulse inside; requester 3 waits.
        drive(1'b0, 4'b1010, 4'b0000, 4'b0010, 4'b0010, 1'b1);
        chk("state_locked", Dbg_state_o, 2);
        drive(1'b0, 4'b1010, 4'b0000, 4'b0010, 4'b0010, 1'b1);
        drive(1'b0, 4'b1011, 4'b0000, 4'b0010, 4'b0001, 1'b1);
        drive(1'b0, 4'b1010, 4'b0000, 4'b0010, 4'b0010, 1'b1);
        drive(1'b0, 4'b1010, 4'b0000, 4'b0010, 4'b0010, 1'b1);
        drive(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk("state_unlocked", Dbg_state_o, 0);
        drive(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b1);
        idle(4);

        // Two reads in flight, then a one-cycle reset: returns must vanish and the
        // pointer (left at 3 by the second read) must restart at requester 1.
        drive(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0);
        drive(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0);
        drive(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk_reset_outputs("midreset");
        drive(1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0010, 1'b1);
        idle(6);

        for (int i = 0; i < 20 && (rd_exp_q.size() > 0 || wr_exp_q.size() > 0); i++)
            @(posedge Clock_50);
        #1;
        chk("rd_queue_drained", rd_exp_q.size(), 0);
        chk("wr_queue_drained", wr_exp_q.size(), 0);
        chk("gnt_queue_drained", gnt_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of SRAM requesters (index 0 = VGA reader, 1 = UART loader, 2 = M1, 3 = M2).
REQ-002 SHALL have parameter READ_LATENCY, default 3, cycles from accepting edge to read data valid.
REQ-003 SHALL have port Clock_50  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Req_i  input  NUM_REQ  per-requester access request.
REQ-006 SHALL have port Req_we_i  input  NUM_REQ  per-requester write enable (1 = write, 0 = read).
REQ-007 SHALL have port Req_addr_i  input  NUM_REQ x 18  per-requester word address.
REQ-008 SHALL have port Req_wdata_i  input  NUM_REQ x 16  per-requester write data.
REQ-009 SHALL have port Lock_i  input  NUM_REQ  per-requester burst-lock request.
REQ-010 SHALL have port Gnt_o  output  NUM_REQ  one-hot grant, combinational, accepted on the same edge.
REQ-011 SHALL have port Rvalid_o  output  NUM_REQ  one-hot read-data-valid strobe.
REQ-012 SHALL have port Rdata_o  output  16  read data, meaningful only while Rvalid_o is nonzero.
REQ-013 SHALL have port SRAM_address_o  output  18  registered SRAM address.
REQ-014 SHALL have port SRAM_write_data_o  output  16  registered SRAM write data.
REQ-015 SHALL have port SRAM_we_n_o  output  1  registered SRAM write enable, active low.
REQ-016 SHALL have port SRAM_read_data_i  input  16  SRAM read data.

Function
REQ-017 SHALL assert at most one Gnt_o bit per cycle, and only for a requester whose Req_i is high.
REQ-018 SHALL treat Req_i & Gnt_o high at a rising edge as an accepted access; requesters hold Req/addr/data stable until granted.
REQ-019 SHALL grant requester 0 whenever Req_i[0] is high, in every state (VGA never starved).
REQ-020 SHALL arbitrate requesters 1..NUM_REQ-1 round-robin when requester 0 is idle; the pointer advances to the index after the winner on each accepted non-zero access.
REQ-021 SHALL have FSM states S_ARB_IDLE (no access last cycle), S_ARB_BUSY (access accepted last cycle, unlocked) and S_ARB_LOCKED (owner k holds bus).
REQ-022 SHALL enter S_ARB_LOCKED with owner k when requester k>0 is accepted with Lock_i[k]=1.
REQ-023 SHALL, in S_ARB_LOCKED, grant only requester 0 or owner k, and the round-robin pointer SHALL not advance.
REQ-024 SHALL leave S_ARB_LOCKED for S_ARB_IDLE in the first cycle Lock_i[k]=0, regardless of Req_i[k].
REQ-025 SHALL, on an accepted access, register the winner's address to SRAM_address_o, register its data to SRAM_write_data_o, and drive SRAM_we_n_o = ~we, all for exactly one cycle (edge+1).
REQ-026 SHALL, in cycles with no accepted access, drive SRAM_we_n_o=1 and hold SRAM_address_o at its last value.
REQ-027 SHALL pulse Rvalid_o[i] for exactly one cycle, READ_LATENCY cycles after the accepting edge of a read by requester i, with Rdata_o = SRAM_read_data_i; it SHALL track this with a READ_LATENCY-deep shift register of {valid, id}.
REQ-028 SHALL sustain one access per cycle with back-to-back reads from different requesters returned in acceptance order.
REQ-029 SHALL not produce Rvalid_o for writes.

Reset
REQ-030 SHALL, while Reset=1, hold Gnt_o=0, Rvalid_o=0, Rdata_o=0, SRAM_we_n_o=1, SRAM_address_o=0, SRAM_write_data_o=0, FSM=S_ARB_IDLE, RR pointer=1, and the latency pipe cleared.
REQ-031 SHALL discard in-flight reads on reset mid-operation: no Rvalid_o after Reset deasserts for reads accepted before it.

Structure
REQ-032 SHALL place NUM_REQ, READ_LATENCY, requester index constants (REQ_VGA, REQ_UART, REQ_M1, REQ_M2) and the arbiter state enum in shared package sram_arb_pkg.
REQ-033 SHALL implement round-robin selection in one sub-module rr_priority_picker (request vector + pointer in, one-hot winner out).

Verification
REQ-034 SHALL verify: Req_i=4'b1110 held 6 cycles, all reads -> grant order 1,2,3,1,2,3; Rvalid_o matching ids 3 cycles after each accept.
REQ-035 SHALL verify: Req_i=4'b1111 -> Gnt_o=4'b0001 every cycle until Req_i[0] drops, then 1,2,3 rotation.
REQ-036 SHALL verify: requester 2 writes 16'hBEEF to addr 18'd27648 -> SRAM_we_n_o=0 with that address/data one cycle after accept; a later read by requester 3 of the same address returns 16'hBEEF on Rvalid_o[3].
REQ-037 SHALL verify: requester 1 with Lock_i[1]=1 for 4 accepts while Req_i[3]=1 -> requester 3 gets no grant until Lock_i[1]=0; a Req_i[0] pulse inside the lock is granted immediately.
REQ-038 SHALL verify: Reset asserted 1 cycle after two back-to-back reads -> Rvalid_o stays 0, SRAM_we_n_o=1, next grant goes to requester 1.
